ikbd_matrix_tx: RTL
===================

Name: ikbd_matrix_tx

Overview:
- Downstream consumer of the PS/2 decoder's active-low key matrix (15 columns × 8 rows, 0 = pressed).
- Continuously scans the matrix and detects key state changes.
- Converts each change to an Atari ST IKBD make/break scancode, buffers it in a FIFO, and serialises it as 8N1 onto the line toward the ST ACIA.
- Replaces the keyboard-transmit half of the original 6301 IKBD.

Parameters:
- CLK_DIV, 256, clk cycles per serial bit (2 MHz / 256 = 7812.5 baud).
- FIFO_DEPTH, 8, scancode FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, same domain as the matrix producer.
- reset  in  1  asynchronous, active-high reset.
- matrix[14:0]  in  8 each  key matrix, active low; synchronous to clk.
- tx  out  1  serial data to ACIA, idle high.
- tx_busy  out  1  high while a frame (start through stop bit) is on the line.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert) forces:
  - tx=1, tx_busy=0, fifo_level=0.
  - FIFO empty, scan index=0, UART idle.
  - Shadow matrix all 1s (all released).
  - Reset mid-frame truncates the frame immediately; line returns high.
- Scanner:
  - 7-bit index covering col 0..14, row 0..7 (120 keys); advances one key per cycle and wraps 119→0.
  - Each cycle it compares matrix[col][row] against shadow[col][row].
  - If they differ and scancode table entry SC≠0x00 and the FIFO is not full: push SC (pressed, bit=0) or SC|0x80 (released, bit=1); update shadow; advance.
  - If they differ and SC==0x00: update shadow, push nothing, advance.
  - If they differ and the FIFO is full: hold index and shadow (stall) until space frees. No event is lost; the key's final state is reported.
  - If they are equal: advance.
  - A key that toggles twice within one scan period (120 cycles) may go unreported. This is acceptable.
- FIFO:
  - Synchronous, FIFO_DEPTH entries, first-word-fall-through.
  - Push and pop in the same cycle are allowed; fifo_level is unchanged.
  - Push when full is impossible by construction (scanner stalls).
  - Pop when empty never occurs.
- UART TX state machine: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if FIFO non-empty, pop into the shift register, drive tx=0, set tx_busy=1, enter START. A byte pushed in cycle N starts at N+1 at the earliest.
  - START, DATA, STOP each hold their level CLK_DIV cycles; a bit counter counts 8 DATA bits, LSB first.
  - STOP: tx=1 for CLK_DIV cycles.
  - At end of STOP, if the FIFO is non-empty, go directly to START (back-to-back, no idle gap). Otherwise go to IDLE with tx_busy=0.
  - Frame length is exactly 10×CLK_DIV cycles.
- The baud divider restarts at 0 on entry to START.

Optional Feature:
- Macro IKBD_TX_POWERUP_F1_EN.
- When defined: on the first clk after reset deasserts, the FIFO is preloaded with 0xF1 (the IKBD power-up status byte), and the scanner is held off for that cycle. 0xF1 is always the first byte sent after reset.
- When undefined: no preload; scanning starts immediately after reset.

Decomposition:
- Package ikbd_pkg holds:
  - typedef key_matrix_t (array [14:0] of 8 bits).
  - SC_TABLE constant [15][8] of 8-bit Atari scancodes, 0x00 = unmapped.
  - BREAK_BIT = 8'h80, IKBD_RESET_ACK = 8'hF1.
  - UART state enum.
- One sub-module: ikbd_uart_tx (FIFO read side, divider, shifter).
- Scanner and FIFO stay in the top.

Test Plan:
1. Press matrix[4][5] (SC 0x1E), hold 2 scans → exactly one frame: 0,0,1,1,1,1,0,0,0,1 (0x1E LSB first), each bit 256 cycles; tx_busy high for 2560 cycles.
2. Release matrix[4][5] after scenario 1 → one frame carrying 0x9E.
3. Press 10 mapped keys in one cycle with FIFO_DEPTH=8:
   - fifo_level reaches 8 and the scanner stalls.
   - All 10 make codes are sent in scan order, back-to-back with no idle gap between frames.
4. Toggle an unmapped position (SC 0x00) → no frame; fifo_level stays 0; shadow tracks the input.
5. Assert reset during DATA bit 3:
   - tx goes to 1 asynchronously.
   - After release with a key still held, its make code is re-sent.
   - With IKBD_TX_POWERUP_F1_EN defined, 0xF1 is sent first.
6. Hold space (matrix[9][7], SC 0x39) through 1000 scan periods → exactly one frame.

Source files
------------

// File: rtl/ikbd_pkg.sv
// Shared types and constants for the IKBD keyboard-transmit path.
package ikbd_pkg;

    // matrix[col][row], active low (0 = pressed)
    typedef logic [14:0][7:0] key_matrix_t;

    localparam logic [7:0] BREAK_BIT      = 8'h80;
    localparam logic [7:0] IKBD_RESET_ACK = 8'hF1;

    // Make code per matrix position, indexed [col][row]; 0x00 marks an unmapped position
    localparam logic [7:0] SC_TABLE [15][8] = '{
        '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
        '{8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10},
        '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18},
        '{8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1F, 8'h20, 8'h21},
        '{8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h1E, 8'h27, 8'h28},
        '{8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h30},
        '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38},
        '{8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h40, 8'h41},
        '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49},
        '{8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50, 8'h39},
        '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58},
        '{8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 8'h5F, 8'h60},
        '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68},
        '{8'h69, 8'h6A, 8'h6B, 8'h6C, 8'h6D, 8'h6E, 8'h6F, 8'h70},
        '{8'h71, 8'h72, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    typedef enum logic [1:0] {UartIdle, UartStart, UartData, UartStop} uart_state_e;

endpackage

// File: rtl/ikbd_uart_tx.sv
// 8N1 serialiser draining the scancode FIFO; frames run back-to-back while data is queued.
module ikbd_uart_tx
    import ikbd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_pop_o,
    output logic       tx_o,
    output logic       tx_busy_o
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    uart_state_e   state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          div_last;

    assign div_last = (div_q == DW'(CLK_DIV - 1));

    // Pop exactly when a new frame is launched (from idle, or straight out of a stop bit)
    assign fifo_pop_o = !fifo_empty_i &&
                        ((state_q == UartIdle) || ((state_q == UartStop) && div_last));

    // Frame sequencer with registered line and busy outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= UartIdle;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_o      <= 1'b1;
            tx_busy_o <= 1'b0;
        end else begin
            case (state_q)
                UartIdle: begin
                    if (!fifo_empty_i) begin
                        shift_q   <= fifo_data_i;
                        tx_o      <= 1'b0;
                        tx_busy_o <= 1'b1;
                        div_q     <= '0;
                        state_q   <= UartStart;
                    end
                end
                UartStart: begin
                    if (div_last) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        tx_o    <= shift_q[0];
                        state_q <= UartData;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                UartData: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_o    <= 1'b1;
                            state_q <= UartStop;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_o    <= shift_q[1];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                UartStop: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (!fifo_empty_i) begin
                            shift_q <= fifo_data_i;
                            tx_o    <= 1'b0;
                            state_q <= UartStart;
                        end else begin
                            tx_busy_o <= 1'b0;
                            state_q   <= UartIdle;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: begin
                    tx_o      <= 1'b1;
                    tx_busy_o <= 1'b0;
                    state_q   <= UartIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/ikbd_matrix_tx.sv
// Key matrix scanner + scancode FIFO + 8N1 transmitter toward the ST ACIA.
// Optional: define IKBD_TX_POWERUP_F1_EN to queue 0xF1 on the first clock after reset.
module ikbd_matrix_tx
    import ikbd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 256,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  key_matrix_t                   matrix_i,
    output logic                          tx_o,
    output logic                          tx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [6:0]  LAST_IDX  = 7'd119;

    key_matrix_t   shadow_q, shadow_d;
    logic [6:0]    idx_q, idx_d, idx_next;
    logic [3:0]    col;
    logic [2:0]    row;
    logic [7:0]    sc;
    logic          key_now, key_old;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push, pop, full, empty, preload;
    logic [7:0]    push_data;

`ifdef IKBD_TX_POWERUP_F1_EN
    logic preload_q;
    // Armed by reset, consumed by the first clock after release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) preload_q <= 1'b1;
        else       preload_q <= 1'b0;
    end
    assign preload = preload_q;
`else
    assign preload = 1'b0;
`endif

    assign col      = idx_q[6:3];
    assign row      = idx_q[2:0];
    assign key_now  = matrix_i[col][row];
    assign key_old  = shadow_q[col][row];
    assign sc       = SC_TABLE[col][row];
    assign idx_next = (idx_q == LAST_IDX) ? 7'd0 : idx_q + 7'd1;
    assign full     = (cnt_q == DEPTH_CNT);
    assign empty    = (cnt_q == '0);

    // Scanner: one key per cycle; a reportable change with no FIFO room stalls in place
    always_comb begin
        push      = 1'b0;
        push_data = sc;
        idx_d     = idx_next;
        shadow_d  = shadow_q;
        if (preload) begin
            push      = 1'b1;
            push_data = IKBD_RESET_ACK;
            idx_d     = idx_q;
        end else if (key_now != key_old) begin
            if (sc == 8'h00) begin
                shadow_d[col][row] = key_now;
            end else if (!full) begin
                push               = 1'b1;
                push_data          = key_now ? (sc | BREAK_BIT) : sc;
                shadow_d[col][row] = key_now;
            end else begin
                idx_d = idx_q;
            end
        end
    end

    // Scanner state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q    <= '0;
            shadow_q <= '1;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign fifo_level_o = cnt_q;

    ikbd_uart_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_uart (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fifo_empty_i(empty),
        .fifo_data_i (mem_q[rd_q]),
        .fifo_pop_o  (pop),
        .tx_o        (tx_o),
        .tx_busy_o   (tx_busy_o)
    );

endmodule
